junction_light_fsm: RTL and testbench
=====================================

JUNCTION_LIGHT_FSM -- requirements
Module: junction_light_fsm

Interface
REQ-001 Parameter GREEN_S, default 20, NS green minimum duration in seconds (legal 1..63).
REQ-002 Parameter YELLOW_S, default 3, yellow duration in seconds for either road (legal 1..63).
REQ-003 Parameter ALLRED_S, default 2, all-red clearance duration in seconds (legal 1..63).
REQ-004 Parameter EW_GREEN_S, default 10, EW green fixed duration in seconds (legal 1..63).
REQ-005 clk1  in  1  system clock; the only clock; all state advances on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clk_1hz  in  1  1 Hz square wave from the clock divider, same clk1 domain, treated as a level.
REQ-008 ew_car  in  1  EW side-road vehicle sensor, level, sampled every clk1 cycle.
REQ-009 maint  in  1  maintenance flash request, level.
REQ-010 ns_light  out  3  NS lamps {red,yellow,green}, registered.
REQ-011 ew_light  out  3  EW lamps {red,yellow,green}, registered.
REQ-012 countdown  out  6  seconds remaining in current phase minus one, registered, for display.

Function
REQ-013 Tick SHALL be a one-clk1-cycle pulse generated on a rising edge of clk_1hz (clk_1hz=1 while its previous registered value=0); tick is internal.
REQ-014 States: NS_GREEN, NS_YELLOW, RED_TO_EW, EW_GREEN, EW_YELLOW, RED_TO_NS, FLASH.
REQ-015 Lamp map: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010; RED_TO_EW/RED_TO_NS both 100; FLASH both {0,clk_1hz,0}.
REQ-016 On entering a timed state, countdown SHALL load that state's duration minus 1; on each tick with countdown>0 it SHALL decrement; on a tick with countdown=0 the state SHALL advance and the next duration minus 1 SHALL load in that same cycle.
REQ-017 A timed state therefore SHALL last exactly its duration in ticks.
REQ-018 Sequence: NS_GREEN -> NS_YELLOW -> RED_TO_EW -> EW_GREEN -> EW_YELLOW -> RED_TO_NS -> NS_GREEN.
REQ-019 ew_req latch SHALL set on any cycle with ew_car=1 and clear on the cycle the FSM enters EW_GREEN; set has priority over clear in the same cycle.
REQ-020 NS_GREEN with countdown=0 on a tick and ew_req=0 SHALL remain in NS_GREEN with countdown held at 0 (green extension).
REQ-021 While extended, the first tick with ew_req=1 SHALL advance to NS_YELLOW.
REQ-022 maint=1 in any state SHALL enter FLASH on the next clk1 edge; countdown SHALL read 0 in FLASH.
REQ-023 maint falling to 0 in FLASH SHALL go to RED_TO_NS with countdown=ALLRED_S-1 on the next clk1 edge, never directly to any green.
REQ-024 Lamp outputs SHALL change only on the clk1 edge that changes state (FLASH yellow excepted); no cycle SHALL show green on both roads.
REQ-025 Arithmetic: countdown 6-bit unsigned, never decremented below 0, never wraps.

Reset
REQ-026 reset_n=0 SHALL immediately force state RED_TO_NS, ns_light=100, ew_light=100, countdown=ALLRED_S-1, ew_req=0, previous clk_1hz register=1.
REQ-027 Previous clk_1hz register resetting to 1 SHALL suppress a spurious tick if clk_1hz is already high at release.
REQ-028 Reset asserted mid-phase SHALL abandon the phase with no further lamp output beyond REQ-026.

Structure
REQ-029 Shared package junction_pkg SHALL hold the state enumeration, lamp encodings (RED=100, YEL=010, GRN=001) and duration defaults.
REQ-030 Tick generation SHALL be one sub-module, tick_edge_det (level in, one-cycle pulse out), reusable for clk_500hz.

Verification (sim params GREEN_S=4, YELLOW_S=2, ALLRED_S=1, EW_GREEN_S=3)
REQ-031 Release reset, ew_car held 1 -> RED_TO_NS 1 tick, NS_GREEN 4 ticks (countdown 3,2,1,0), NS_YELLOW 2, RED_TO_EW 1, EW_GREEN 3, EW_YELLOW 2, loop.
REQ-032 ew_car=0 throughout -> NS_GREEN held, countdown=0 after 4 ticks; pulse ew_car 1 cycle between ticks -> NS_YELLOW on the next tick.
REQ-033 clk_1hz=1 at reset release -> no tick until the next 0->1 edge; countdown stays at ALLRED_S-1=0 until then.
REQ-034 maint=1 during EW_GREEN -> FLASH next cycle, both yellows track clk_1hz, countdown=0; maint=0 -> RED_TO_NS, countdown=0, then NS_GREEN.
REQ-035 reset_n pulsed low mid-EW_GREEN between clk1 edges -> lamps 100/100 immediately, ew_req=0.
REQ-036 Assert every cycle: never ns_light=001 and ew_light=001 simultaneously; countdown never exceeds its phase duration minus 1.

Source files
------------

// File: rtl/junction_pkg.sv
// Shared types, lamp encodings and phase sequencing for the junction light controller.
package junction_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    RED_TO_EW,
    EW_GREEN,
    EW_YELLOW,
    RED_TO_NS,
    FLASH
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int GREEN_S_DEF    = 20;
  localparam int YELLOW_S_DEF   = 3;
  localparam int ALLRED_S_DEF   = 2;
  localparam int EW_GREEN_S_DEF = 10;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lamps_t;

  // Steady lamp pattern of each phase; FLASH is blank here and gets its yellow overlaid by the caller.
  function automatic lamps_t lamps_for(state_t s);
    lamps_t l;
    l = '{ns: LAMP_RED, ew: LAMP_RED};
    case (s)
      NS_GREEN:  l = '{ns: LAMP_GRN, ew: LAMP_RED};
      NS_YELLOW: l = '{ns: LAMP_YEL, ew: LAMP_RED};
      EW_GREEN:  l = '{ns: LAMP_RED, ew: LAMP_GRN};
      EW_YELLOW: l = '{ns: LAMP_RED, ew: LAMP_YEL};
      FLASH:     l = '{ns: LAMP_OFF, ew: LAMP_OFF};
      default:   l = '{ns: LAMP_RED, ew: LAMP_RED};
    endcase
    return l;
  endfunction

  function automatic state_t next_phase(state_t s);
    state_t n;
    case (s)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = RED_TO_EW;
      RED_TO_EW: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = RED_TO_NS;
      default:   n = NS_GREEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/junction_light_fsm_if.sv
// Sensor/request inputs and lamp/display outputs of the junction controller.
interface junction_light_fsm_if;
  logic       clk_1hz;
  logic       ew_car;
  logic       maint;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [5:0] countdown;

  modport master (
    output clk_1hz, ew_car, maint,
    input  ns_light, ew_light, countdown
  );

  modport slave (
    input  clk_1hz, ew_car, maint,
    output ns_light, ew_light, countdown
  );
endinterface

// File: rtl/tick_edge_det.sv
// Rising-edge detector: one-cycle pulse when a same-domain level goes 0->1.
module tick_edge_det #(
  parameter logic PREV_RESET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Resetting prev high keeps a level that is already high at release from counting as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= PREV_RESET;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/junction_light_fsm.sv
// Two-road junction controller: timed phases, demand-driven NS green extension, maintenance flash.
module junction_light_fsm
  import junction_pkg::*;
#(
  parameter int GREEN_S    = GREEN_S_DEF,
  parameter int YELLOW_S   = YELLOW_S_DEF,
  parameter int ALLRED_S   = ALLRED_S_DEF,
  parameter int EW_GREEN_S = EW_GREEN_S_DEF
) (
  input  logic clk1,
  input  logic reset_n,
  junction_light_fsm_if.slave bus
);

  state_t     state;
  logic [5:0] countdown;
  logic [2:0] ns_q;
  logic [2:0] ew_q;
  logic       ew_req;
  logic       tick;
  logic       enter_ew_green;
  logic       hold_green;

  function automatic logic [5:0] load_for(state_t s);
    logic [5:0] v;
    case (s)
      NS_GREEN:  v = 6'(GREEN_S - 1);
      NS_YELLOW: v = 6'(YELLOW_S - 1);
      RED_TO_EW: v = 6'(ALLRED_S - 1);
      EW_GREEN:  v = 6'(EW_GREEN_S - 1);
      EW_YELLOW: v = 6'(YELLOW_S - 1);
      RED_TO_NS: v = 6'(ALLRED_S - 1);
      default:   v = 6'd0;
    endcase
    return v;
  endfunction

  tick_edge_det #(.PREV_RESET(1'b1)) u_tick (
    .clk   (clk1),
    .rst_n (reset_n),
    .level (bus.clk_1hz),
    .pulse (tick)
  );

  assign enter_ew_green = !bus.maint && (state == RED_TO_EW) && tick && (countdown == 6'd0);
  // NS green stays on past its minimum until the side road has asked for a turn.
  assign hold_green     = (state == NS_GREEN) && !ew_req;

  // NOTE: all state in this block uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RED_TO_NS;
      countdown <= 6'(ALLRED_S - 1);
      ns_q      <= LAMP_RED;
      ew_q      <= LAMP_RED;
      ew_req    <= 1'b0;
    end else begin
      if (bus.ew_car)          ew_req <= 1'b1;
      else if (enter_ew_green) ew_req <= 1'b0;

      if (bus.maint) begin
        state     <= FLASH;
        countdown <= 6'd0;
        ns_q      <= {1'b0, bus.clk_1hz, 1'b0};
        ew_q      <= {1'b0, bus.clk_1hz, 1'b0};
      end else if (state == FLASH) begin
        // Leaving maintenance always clears through all-red before any green.
        state     <= RED_TO_NS;
        countdown <= 6'(ALLRED_S - 1);
        ns_q      <= LAMP_RED;
        ew_q      <= LAMP_RED;
      end else if (tick) begin
        if (countdown != 6'd0) begin
          countdown <= countdown - 6'd1;
        end else if (!hold_green) begin
          state     <= next_phase(state);
          countdown <= load_for(next_phase(state));
          ns_q      <= lamps_for(next_phase(state)).ns;
          ew_q      <= lamps_for(next_phase(state)).ew;
        end
      end
    end
  end

  assign bus.ns_light  = ns_q;
  assign bus.ew_light  = ew_q;
  assign bus.countdown = countdown;

endmodule

// File: tb/tb_junction_light_fsm.sv
// Directed bench for junction_light_fsm with short phase durations.
module tb_junction_light_fsm;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int EG = 3;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] N = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic clk1    = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk1 = ~clk1;

  junction_light_fsm_if bus();

  junction_light_fsm #(
    .GREEN_S    (G),
    .YELLOW_S   (Y),
    .ALLRED_S   (AR),
    .EW_GREEN_S (EG)
  ) dut (
    .clk1    (clk1),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] v(input logic [2:0] n, input logic [2:0] e, input int c);
    return {4'h0, n, e, 6'(c)};
  endfunction

  function automatic logic [15:0] obs();
    return {4'h0, bus.ns_light, bus.ew_light, bus.countdown};
  endfunction

  // Largest countdown each visible lamp pattern may show; -1 marks an illegal pattern.
  function automatic int phase_limit(input logic [2:0] n, input logic [2:0] e);
    case ({n, e})
      6'b001_100:             return G - 1;
      6'b010_100:             return Y - 1;
      6'b100_001:             return EG - 1;
      6'b100_010:             return Y - 1;
      6'b100_100:             return AR - 1;
      6'b000_000, 6'b010_010: return 0;
      default:                return -1;
    endcase
  endfunction

  always @(negedge clk1) begin
    int lim;
    lim = phase_limit(bus.ns_light, bus.ew_light);
    check("no_dual_green", 16'(bus.ns_light == N && bus.ew_light == N), 16'd0);
    check("phase_cnt", 16'(lim >= 0 && int'(bus.countdown) <= lim), 16'd1);
  end

  task automatic one_sec();
    @(negedge clk1) bus.clk_1hz = 1'b1;
    @(negedge clk1) bus.clk_1hz = 1'b0;
  endtask

  task automatic do_reset(input logic hz);
    @(negedge clk1);
    reset_n     = 1'b0;
    bus.clk_1hz = hz;
    bus.maint   = 1'b0;
    @(negedge clk1);
    check("rst_state", obs(), v(R, R, AR - 1));
    check("rst_ew_req", 16'(dut.ew_req), 16'd0);
    reset_n = 1'b1;
  endtask

  logic [15:0] seq [14];

  initial begin
    seq[0]  = v(N, R, 3); seq[1]  = v(N, R, 2); seq[2]  = v(N, R, 1); seq[3]  = v(N, R, 0);
    seq[4]  = v(A, R, 1); seq[5]  = v(A, R, 0); seq[6]  = v(R, R, 0); seq[7]  = v(R, N, 2);
    seq[8]  = v(R, N, 1); seq[9]  = v(R, N, 0); seq[10] = v(R, A, 1); seq[11] = v(R, A, 0);
    seq[12] = v(R, R, 0); seq[13] = v(N, R, 3);

    bus.clk_1hz = 1'b0;
    bus.ew_car  = 1'b0;
    bus.maint   = 1'b0;
    #1 reset_n  = 1'b0;
    @(negedge clk1);
    check("init_reset", obs(), v(R, R, AR - 1));

    // Full cycle with continuous EW demand.
    bus.ew_car = 1'b1;
    reset_n    = 1'b1;
    for (int i = 0; i < 14; i++) begin
      one_sec();
      check($sformatf("cycle_t%0d", i + 1), obs(), seq[i]);
    end

    // No EW demand: NS green is extended, then a single-cycle car pulse releases it.
    bus.ew_car = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      one_sec();
      check($sformatf("extend_t%0d", i + 1), obs(), v(N, R, (i < 3) ? 3 - i : 0));
    end
    @(negedge clk1) bus.ew_car = 1'b1;
    @(negedge clk1) bus.ew_car = 1'b0;
    check("extend_pulse", obs(), v(N, R, 0));
    one_sec();
    check("extend_release", obs(), v(A, R, Y - 1));

    // clk_1hz already high at reset release must not tick.
    do_reset(1'b1);
    repeat (4) @(negedge clk1);
    check("hz_high_no_tick", obs(), v(R, R, 0));
    bus.clk_1hz = 1'b0;
    @(negedge clk1);
    check("hz_fall_no_tick", obs(), v(R, R, 0));
    one_sec();
    check("hz_first_edge", obs(), v(N, R, G - 1));

    // Maintenance flash entered from EW green.
    bus.ew_car = 1'b1;
    do_reset(1'b0);
    repeat (8) one_sec();
    check("flash_pre", obs(), v(R, N, EG - 1));
    bus.maint = 1'b1;
    @(negedge clk1);
    check("flash_enter", obs(), v(O, O, 0));
    bus.clk_1hz = 1'b1;
    @(negedge clk1);
    check("flash_yel_on", obs(), v(A, A, 0));
    bus.clk_1hz = 1'b0;
    @(negedge clk1);
    check("flash_yel_off", obs(), v(O, O, 0));
    bus.maint = 1'b0;
    @(negedge clk1);
    check("flash_exit", obs(), v(R, R, AR - 1));
    one_sec();
    check("flash_to_green", obs(), v(N, R, G - 1));

    // Asynchronous reset pulse in the middle of EW green.
    do_reset(1'b0);
    repeat (8) one_sec();
    check("mid_pre", obs(), v(R, N, EG - 1));
    check("mid_pre_req", 16'(dut.ew_req), 16'd1);
    @(posedge clk1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_lamps", obs(), v(R, R, AR - 1));
    check("mid_rst_req", 16'(dut.ew_req), 16'd0);
    #1 reset_n = 1'b1;
    bus.ew_car = 1'b0;
    @(negedge clk1);
    check("mid_rst_hold", obs(), v(R, R, AR - 1));
    one_sec();
    check("mid_rst_restart", obs(), v(N, R, G - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
